// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage write/flush strobes from load-use,
// branch redirect and data-memory wait/timeout, plus saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             branch_taken_ex,
    input  logic             ex_mem_mem_access,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, WAIT, ABORT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t     state, state_n;
    logic [7:0] wait_cnt, wait_n;
    logic       err_q, err_n;
    logic       load_use, mem_busy, redirect;

    always_comb begin
        load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                   ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
        mem_busy = ex_mem_mem_access && !mem_ready && (state != ABORT);

        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        redirect     = 1'b0;

        // A frozen pipeline holds everything; branch/load-use are re-seen on release.
        if (!res && !mem_busy) begin
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            if (branch_taken_ex) begin
                redirect    = 1'b1;
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        err_n   = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_busy) begin
                    state_n = WAIT;
                    wait_n  = 8'd1;
                end
            end
            WAIT: begin
                if (!mem_busy) begin
                    state_n = RUN;
                    wait_n  = 8'd0;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_n = ABORT;
                    wait_n  = 8'd0;
                    err_n   = 1'b1;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end
            end
            ABORT: begin
                state_n = RUN;
                wait_n  = 8'd0;
            end
            default: begin
                state_n = RUN;
                wait_n  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            err_q     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            err_q    <= err_n;
            if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Gated so a pulse pending when reset arrives never shows during reset.
    assign mem_err = err_q && !res;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: reset/table vectors, timeout and saturation sequences,
// then randomized traffic against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MW = 4;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    // strobe order: {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_w}
    localparam logic [6:0] S_OFF  = 7'b0000000;
    localparam logic [6:0] S_RUN  = 7'b1101011;
    localparam logic [6:0] S_BUB  = 7'b0001111;
    localparam logic [6:0] S_BR   = 7'b1111111;

    logic clk = 1'b0;
    logic res = 1'b1;
    logic id_ex_mem_read = 1'b0;
    logic [4:0] id_ex_rd = '0, if_id_rs1 = '0, if_id_rs2 = '0;
    logic branch_taken_ex = 1'b0, ex_mem_mem_access = 1'b0, mem_ready = 1'b0;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, mem_wb_write, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int compared = 0;
    int mismatched = 0;

    pipeline_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .res(res),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .branch_taken_ex(branch_taken_ex), .ex_mem_mem_access(ex_mem_mem_access),
        .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] strobes();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_write, mem_wb_write};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic br, input logic acc, input logic rdy);
        @(negedge clk);
        res = r; id_ex_mem_read = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
        branch_taken_ex = br; ex_mem_mem_access = acc; mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic r, mr;
        logic [4:0] rd, rs1, rs2;
        logic br, acc, rdy;
        logic [6:0] s;
        int stall, flush;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic br, input logic acc, input logic rdy,
                                input logic [6:0] s, input int st, input int fl);
        vec_t v;
        v.r = r; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.br = br; v.acc = acc; v.rdy = rdy; v.s = s; v.stall = st; v.flush = fl;
        return v;
    endfunction

    // behavioural model state
    int  m_frozen, m_stall, m_flush;
    bit  m_abort, m_err;

    initial begin
        tbl[0] = mk(1, 1, 5, 0, 5, 1, 1, 0, S_OFF, 0, 0);
        tbl[1] = mk(1, 1, 5, 5, 1, 0, 1, 0, S_OFF, 0, 0);
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, S_RUN, 0, 0);
        tbl[3] = mk(0, 1, 5, 3, 5, 0, 0, 0, S_BUB, 1, 0);
        tbl[4] = mk(0, 1, 0, 0, 0, 0, 0, 0, S_RUN, 1, 0);
        tbl[5] = mk(0, 1, 7, 7, 2, 1, 0, 0, S_BR,  1, 1);
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 1, 0, S_OFF, 2, 1);
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 1, 0, S_OFF, 3, 1);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 1, 0, S_OFF, 4, 1);
        tbl[9] = mk(0, 0, 0, 0, 0, 0, 1, 1, S_RUN, 4, 1);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].r, tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                  tbl[i].br, tbl[i].acc, tbl[i].rdy);
            chk($sformatf("tbl%0d_strobes", i), 32'(strobes()), 32'(tbl[i].s));
            tick();
            chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].stall));
            chk($sformatf("tbl%0d_flush", i), 32'(flush_cnt), 32'(tbl[i].flush));
            chk($sformatf("tbl%0d_err", i), 32'(mem_err), 32'd0);
        end

        // Timeout: MW frozen cycles, then one ABORT cycle that advances with mem_err.
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int k = 0; k < MW; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("to_freeze%0d", k), 32'(strobes()), 32'(S_OFF));
            tick();
            chk($sformatf("to_err%0d", k), 32'(mem_err), 32'(k == MW - 1));
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_abort_strobes", 32'(strobes()), 32'(S_RUN));
        chk("to_abort_err", 32'(mem_err), 32'd1);
        tick();
        chk("to_err_cleared", 32'(mem_err), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_refreeze", 32'(strobes()), 32'(S_OFF));
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("to_release", 32'(strobes()), 32'(S_RUN));
        tick();
        chk("to_stall", 32'(stall_cnt), 32'(MW + 1));

        // Saturation of stall_cnt with back-to-back bubbles.
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 9, 9, 0, 0, 0, 0);
            if (k == 0 || k == 19) chk($sformatf("sat_bubble%0d", k), 32'(strobes()), 32'(S_BUB));
            tick();
        end
        chk("sat_stall", 32'(stall_cnt), 32'(SAT));

        // Reset during WAIT: no pulse, and wait count restarts from scratch.
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        chk("rmw_strobes", 32'(strobes()), 32'(S_OFF));
        tick();
        chk("rmw_err", 32'(mem_err), 32'd0);
        chk("rmw_stall", 32'(stall_cnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rmw_run", 32'(strobes()), 32'(S_RUN));
        tick();
        chk("rmw_err2", 32'(mem_err), 32'd0);
        for (int k = 0; k < MW; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            tick();
            chk($sformatf("rmw_wait_err%0d", k), 32'(mem_err), 32'(k == MW - 1));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, mr, br, acc, rdy, frozen, lu;
            logic [4:0] rd, rs1, rs2;
            logic [6:0] exp;
            r   = (i == 0) || ($urandom_range(0, 39) == 0);
            mr  = $urandom_range(0, 1);
            rd  = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            br  = ($urandom_range(0, 4) == 0);
            acc = $urandom_range(0, 1);
            rdy = ($urandom_range(0, 2) == 0);
            drive(r, mr, rd, rs1, rs2, br, acc, rdy);

            frozen = acc && !rdy && !m_abort;
            lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
            if (r || frozen) exp = S_OFF;
            else if (br)     exp = S_BR;
            else if (lu)     exp = S_BUB;
            else             exp = S_RUN;
            chk("rnd_strobes", 32'(strobes()), 32'(exp));
            tick();

            if (r) begin
                m_frozen = 0; m_abort = 0; m_err = 0; m_stall = 0; m_flush = 0;
            end else begin
                if (!exp[6]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
                if (exp[4] && exp[6]) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
                m_abort = 0; m_err = 0;
                if (frozen) begin
                    m_frozen++;
                    if (m_frozen == MW) begin
                        m_abort = 1; m_err = 1; m_frozen = 0;
                    end
                end else begin
                    m_frozen = 0;
                end
            end
            chk("rnd_stall", 32'(stall_cnt), 32'(m_stall));
            chk("rnd_flush", 32'(flush_cnt), 32'(m_flush));
            chk("rnd_err", 32'(mem_err), 32'(m_err && !res));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage write-enable and flush strobes from three sources:
  - load-use hazard detection,
  - taken-branch redirect from EX,
  - a data-memory ready handshake with timeout.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- MAX_WAIT, 8, maximum consecutive data-memory wait cycles before forced abort (legal range 2..255).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- res  input  1  synchronous active-high reset.
- id_ex_mem_read  input  1  instruction in EX is a load.
- id_ex_rd  input  5  destination register of instruction in EX.
- if_id_rs1  input  5  source register 1 of instruction in ID.
- if_id_rs2  input  5  source register 2 of instruction in ID.
- branch_taken_ex  input  1  branch/jump in EX resolved taken.
- ex_mem_mem_access  input  1  instruction in MEM performs a load or store.
- mem_ready  input  1  data memory completes access this cycle.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID register write enable.
- if_id_flush  output  1  IF/ID register clear to NOP.
- id_ex_write  output  1  ID/EX register write enable.
- id_ex_flush  output  1  ID/EX register clear to NOP (bubble).
- ex_mem_write  output  1  EX/MEM register write enable.
- mem_wb_write  output  1  MEM/WB register write enable.
- mem_err  output  1  registered one-cycle pulse: memory access aborted by timeout.
- stall_cnt  output  CNT_W  saturating count of cycles with pc_write=0.
- flush_cnt  output  CNT_W  saturating count of branch-flush events.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-high (res).
  - While res=1:
    - All *_write = 0.
    - All *_flush = 0.
    - mem_err = 0.
  - On the res=1 edge: state <= RUN, wait_cnt <= 0, stall_cnt <= 0, flush_cnt <= 0.
  - A reset mid-wait abandons the wait with no mem_err.
- States:
  - RUN: normal operation.
  - WAIT: memory stall in progress.
  - ABORT: single forced-release cycle after a timeout.
- Output timing:
  - Strobe outputs are combinational from the current state and current inputs (zero latency).
  - State, wait_cnt, counters and mem_err are registered.
- Condition definitions (evaluated every cycle):
  - load_use = id_ex_mem_read & (id_ex_rd != 0) & (id_ex_rd == if_id_rs1 | id_ex_rd == if_id_rs2).
  - mem_busy = ex_mem_mem_access & ~mem_ready & (state != ABORT).
- Priority, highest first:
  1. mem_busy (freeze):
     - All *_write = 0 and all *_flush = 0; the whole pipeline holds.
     - A pending branch or load-use is re-evaluated after release, since EX and ID are held.
  2. branch_taken_ex (redirect):
     - if_id_flush = 1, id_ex_flush = 1; all writes = 1.
     - The PC loads the target.
     - Overrides load_use, because the ID instruction is discarded.
     - flush_cnt increments.
  3. load_use (bubble):
     - pc_write = 0, if_id_write = 0, id_ex_flush = 1.
     - id_ex_write, ex_mem_write and mem_wb_write = 1.
  4. Otherwise:
     - All writes = 1, all flushes = 0.
- Flush semantics: when a flush is asserted together with write=1 on the same register, the flush takes priority (the register loads a NOP).
- State transitions:
  - RUN -> WAIT when mem_busy; wait_cnt <= 1.
  - WAIT, mem_ready=1 -> RUN; wait_cnt <= 0. The release cycle applies priorities 2-4 normally.
  - WAIT, mem_ready=0, wait_cnt < MAX_WAIT-1 -> wait_cnt increments.
  - WAIT, mem_ready=0, wait_cnt == MAX_WAIT-1 -> ABORT; mem_err <= 1 for exactly one cycle.
  - ABORT -> RUN unconditionally. mem_busy is forced false, so the pipeline advances and MEM/WB captures whatever data is present.
  - mem_ready asserted while ex_mem_mem_access=0 is ignored.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_write=0 (freeze or bubble).
  - flush_cnt increments on each cycle where the redirect is applied.
  - Both saturate at all-ones with no wrap.
- Register x0: a load with id_ex_rd=0 never causes a bubble.

Test Plan:
- Reset: res=1 for 2 cycles with arbitrary inputs -> all writes/flushes 0, mem_err=0, stall_cnt=flush_cnt=0. First cycle after res=0 with quiet inputs -> all writes 1.
- Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5 -> pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1; stall_cnt=1 next cycle. Repeat with id_ex_rd=0 -> no bubble.
- Branch over load-use: branch_taken_ex=1 together with a load_use condition -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt increments, stall_cnt unchanged.
- Memory wait: ex_mem_mem_access=1, mem_ready low 3 cycles then high -> all writes 0 for 3 cycles, all writes 1 on the 4th; stall_cnt=3; no mem_err.
- Timeout: MAX_WAIT=4, mem_ready held 0 -> freeze for 4 cycles, mem_err pulses once in the 5th cycle (ABORT) where all writes = 1, then back to RUN.
- Saturation and reset mid-wait: CNT_W=4, 20 bubble cycles -> stall_cnt=15. Assert res during WAIT -> state RUN, wait_cnt=0, no mem_err.
